// File: rtl/mc_controller.sv
// mc_controller: Moore-FSM control unit for a multicycle RV32I subset core
//   (lw, sw, R-type, I-type ALU, beq, jal) with a shared ALU and shared memory.
// Latency: lw 5, sw/R/I/jal 4, beq 3 cycles; strobes are combinational from state.
// Backpressure: mem_ready=0 holds FETCH/MEMREAD/MEMWRITE one cycle per low cycle.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   op/funct3/funct7b5   instruction fields from IR
//   zero, mem_ready      ALU zero flag, memory access-complete handshake
//   pc_write..reg_write  datapath enables and mux selects
//   illegal              high while trapped on an undecodable opcode
//   instret, state_dbg   retired-instruction counter, current state
module mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [1:0]       imm_src,
  output logic             reg_write,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_dbg
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [CNT_W-1:0] r_instret;
  logic             w_retire;

  logic       w_pc_update, w_branch, w_adr_src, w_mem_write, w_ir_write;
  logic       w_reg_write, w_illegal;
  logic [1:0] w_alu_op, w_result_src, w_alu_src_a, w_alu_src_b;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011:             w_next = S_EXECR;
          7'b0010011:             w_next = S_EXECI;
          7'b1100011:             w_next = S_BEQ;
          7'b1101111:             w_next = S_JAL;
          default:                w_next = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_TRAP;
    endcase
  end

  // Moore output decode; FETCH gates its strobes with mem_ready so a stalled
  // fetch neither loads IR nor advances PC.
  always_comb begin
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_alu_op     = 2'b00;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = mem_ready;
        w_pc_update  = mem_ready;
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
      end
      S_MEMREAD:  w_adr_src = 1'b1;
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b10;
      end
      S_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
      end
      S_ALUWB:    w_reg_write = 1'b1;
      S_BEQ: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b01;
        w_branch    = 1'b1;
      end
      S_JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_update = 1'b1;
      end
      S_TRAP:     w_illegal = 1'b1;
      default:    ;
    endcase
  end

  // ALU decoder; funct3=000 is sub only for R-type (op[5]) with funct7b5,
  // so addi with IR[30] set still adds.
  always_comb begin
    alu_control = 3'b000;
    case (w_alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      7'b0100011: imm_src = 2'b01;
      7'b1100011: imm_src = 2'b10;
      7'b1101111: imm_src = 2'b11;
      default:    imm_src = 2'b00;
    endcase
  end

  // An instruction retires on its final transition back to FETCH.
  assign w_retire = (w_next == S_FETCH) &&
                    ((r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                     (r_state == S_ALUWB) || (r_state == S_BEQ));

  always_ff @(posedge clk) begin
    if (reset)         r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + CNT_W'(1);
  end

  // Architectural strobes are suppressed while reset is asserted.
  assign pc_write   = ~reset & (w_pc_update | (w_branch & zero));
  assign ir_write   = ~reset & w_ir_write;
  assign mem_write  = ~reset & w_mem_write;
  assign reg_write  = ~reset & w_reg_write;
  assign illegal    = ~reset & w_illegal;
  assign adr_src    = w_adr_src;
  assign result_src = w_result_src;
  assign alu_src_a  = w_alu_src_a;
  assign alu_src_b  = w_alu_src_b;
  assign instret    = r_instret;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized bench for mc_controller against a phase-list
//   reference model (per-instruction state sequence plus stall insertion).
// Inputs are driven on the falling edge and outputs sampled 1 time unit later.
module tb_mc_controller;
  logic        clk = 1'b0;
  logic        reset, zero, mem_ready, funct7b5;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_control;
  logic [3:0]  instret;
  logic [3:0]  state_dbg;

  int n_chk  = 0;
  int n_pass = 0;
  int model_cnt = 0;   // retired count modulo 16 (CNT_W = 4 exercises wrap)

  mc_controller #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .reg_write(reg_write), .illegal(illegal),
    .instret(instret), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [2:0] exp_alu(input int s, input logic [6:0] o,
                                         input logic [2:0] f3, input logic f7);
    if (s == 9) return 3'b001;                 // beq compares by subtraction
    if (s != 6 && s != 7) return 3'b000;       // address/PC arithmetic adds
    case (f3)
      3'd0:    return (o == 7'h33 && f7) ? 3'b001 : 3'b000;   // sub vs add/addi
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    case (o)
      7'h23:   return 2'b01;
      7'h63:   return 2'b10;
      7'h6F:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Entered just after a falling edge; leaves just after a falling edge.
  // stall_mem < 0: random mem_ready everywhere; else FETCH is ready at once
  // and MEMREAD/MEMWRITE see exactly stall_mem not-ready cycles.
  // zmode: 0/1 fixed zero flag, 2 random.
  task automatic run_instr(input logic [31:0] ins, input int stall_mem, input int zmode);
    int ph[$];
    int s, stalls;
    bit w, rdy, zr, adv;
    logic [6:0] o;
    o = ins[6:0];
    case (o)
      7'h03:   ph = '{0, 1, 2, 3, 4};
      7'h23:   ph = '{0, 1, 2, 5};
      7'h33:   ph = '{0, 1, 6, 8};
      7'h13:   ph = '{0, 1, 7, 8};
      7'h63:   ph = '{0, 1, 9};
      default: ph = '{0, 1, 10, 8};
    endcase
    op = o; funct3 = ins[14:12]; funct7b5 = ins[30];
    foreach (ph[k]) begin
      stalls = 0;
      adv = 1'b0;
      while (!adv) begin
        s = ph[k];
        w = (s == 0 || s == 3 || s == 5);
        if (stall_mem < 0) rdy = w ? ((stalls >= 3) || ($urandom_range(0, 99) < 70))
                                   : 1'($urandom_range(0, 1));
        else if (s == 3 || s == 5) rdy = (stalls >= stall_mem);
        else rdy = 1'b1;
        zr = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
        mem_ready = rdy; zero = zr;
        #1;
        check_eq("state", 32'(state_dbg), 32'(s));
        check_eq("pc_write", 32'(pc_write), 32'((s == 0 && rdy) || s == 10 || (s == 9 && zr)));
        check_eq("ir_write", 32'(ir_write), 32'(s == 0 && rdy));
        check_eq("mem_write", 32'(mem_write), 32'(s == 5));
        check_eq("reg_write", 32'(reg_write), 32'(s == 4 || s == 8));
        check_eq("adr_src", 32'(adr_src), 32'(s == 3 || s == 5));
        check_eq("result_src", 32'(result_src), (s == 0) ? 32'd2 : (s == 4) ? 32'd1 : 32'd0);
        check_eq("alu_control", 32'(alu_control), 32'(exp_alu(s, o, ins[14:12], ins[30])));
        check_eq("imm_src", 32'(imm_src), 32'(exp_imm(o)));
        check_eq("illegal", 32'(illegal), 32'd0);
        check_eq("instret", 32'(instret), 32'(model_cnt));
        adv = !w || rdy;
        if (!adv) stalls++;
        @(negedge clk);
      end
    end
    model_cnt = (model_cnt + 1) % 16;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    case ($urandom_range(0, 5))
      0: ins[6:0] = 7'h33;
      1: ins[6:0] = 7'h13;
      2: begin ins[6:0] = 7'h03; ins[14:12] = 3'b010; end
      3: begin ins[6:0] = 7'h23; ins[14:12] = 3'b010; end
      4: begin ins[6:0] = 7'h63; ins[14:12] = 3'b000; end
      default: ins[6:0] = 7'h6F;
    endcase
    return ins;
  endfunction

  initial begin
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0;
    op = 7'h33; funct3 = 3'd0; funct7b5 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_state", 32'(state_dbg), 32'd0);
    check_eq("rst_instret", 32'(instret), 32'd0);
    check_eq("rst_pc_write", 32'(pc_write), 32'd0);
    check_eq("rst_ir_write", 32'(ir_write), 32'd0);
    check_eq("rst_mem_write", 32'(mem_write), 32'd0);
    check_eq("rst_reg_write", 32'(reg_write), 32'd0);
    check_eq("rst_illegal", 32'(illegal), 32'd0);
    reset = 1'b0;

    // Directed program from the test plan.
    run_instr(32'h002081B3, 0, 0);   // add
    run_instr(32'h402081B3, 0, 0);   // sub
    run_instr(32'h00402103, 2, 0);   // lw, two wait cycles in MEMREAD
    run_instr(32'h00202223, 0, 0);   // sw
    run_instr(32'h00202223, 3, 0);   // sw with mem_write held while waiting
    run_instr(32'h00000463, 0, 1);   // beq taken
    run_instr(32'h00000463, 0, 0);   // beq not taken
    run_instr(32'h008000EF, 0, 0);   // jal

    // Random program; 4-bit instret wraps several times.
    for (int i = 0; i < 60; i++) run_instr(rand_instr(), -1, 2);

    // Illegal opcode: trap and hold with instret frozen.
    op = 7'h00; funct3 = 3'd0; funct7b5 = 1'b0; mem_ready = 1'b1;
    #1;
    check_eq("trap_fetch", 32'(state_dbg), 32'd0);
    @(negedge clk); #1;
    check_eq("trap_decode", 32'(state_dbg), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      #1;
      check_eq("trap_state", 32'(state_dbg), 32'd11);
      check_eq("trap_illegal", 32'(illegal), 32'd1);
      check_eq("trap_instret", 32'(instret), 32'(model_cnt));
      check_eq("trap_strobes", {28'd0, pc_write, ir_write, mem_write, reg_write}, 32'd0);
      @(negedge clk);
    end
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk); #1;
    check_eq("post_trap_state", 32'(state_dbg), 32'd0);
    check_eq("post_trap_illegal", 32'(illegal), 32'd0);
    check_eq("post_trap_instret", 32'(instret), 32'd0);
    check_eq("post_trap_ir_write", 32'(ir_write), 32'd0);
    model_cnt = 0;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) run_instr(rand_instr(), -1, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multicycle control unit for the RV32I subset core (lw, sw, R-type, addi-class I-type, beq, jal). It replaces the single-cycle main/ALU decoders with a Moore FSM that sequences a shared-ALU, shared-memory datapath. The datapath has these registers: IR, OldPC, A, B, ALUOut and Data. The block also stalls on a memory ready handshake, traps undecodable opcodes and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter instret.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high; sampled on the rising edge of clk
op  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7b5  in  1  IR[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  PC register load enable
adr_src  out  1  memory address select: 0 = PC, 1 = Result
mem_write  out  1  data memory write strobe
ir_write  out  1  IR/OldPC load enable
result_src  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = A
alu_src_b  out  2  ALU B select: 00 = B, 01 = ImmExt, 10 = constant 4
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
imm_src  out  2  immediate format: 00 I, 01 S, 10 B, 11 J
reg_write  out  1  register file write enable
illegal  out  1  high while the FSM is in the TRAP state
instret  out  CNT_W  count of retired instructions
state_dbg  out  4  current state encoding, for waveforms

Behaviour:
- Reset: state goes to FETCH and instret goes to 0. While reset=1, pc_write, ir_write, mem_write and reg_write are forced to 0 and illegal=0. A reset mid-instruction abandons that instruction.
- All outputs are a combinational decode of the state, except three:
  - pc_write = PCUpdate | (Branch & zero).
  - imm_src is decoded from op: lw/addi 00, sw 01, beq 10, jal 11, other 00.
  - alu_control is decoded from ALUOp. ALUOp 00 gives add; 01 gives sub; 10 decodes funct3:
    - 000: sub only if funct7b5 & op[5], else add.
    - 010: slt. 110: or. 111: and. Any other funct3: add.
- Unlisted outputs in a state are 0. ALUOp defaults to 00.
- States and transitions:
  - FETCH(0): adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10.
    - If mem_ready=1: ir_write=1, PCUpdate=1, go to DECODE.
    - If mem_ready=0: stay in FETCH; strobes stay 0.
  - DECODE(1): alu_src_a=01, alu_src_b=01 (precomputes the branch target into ALUOut).
    - op 0000011 or 0100011 -> MEMADR. 0110011 -> EXECR. 0010011 -> EXECI. 1100011 -> BEQ. 1101111 -> JAL.
    - Any other op -> TRAP.
  - MEMADR(2): alu_src_a=10, alu_src_b=01. Goes to MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD(3): adr_src=1, result_src=00. Goes to MEMWB when mem_ready=1; otherwise holds.
  - MEMWB(4): result_src=01, reg_write=1. Goes to FETCH.
  - MEMWRITE(5): adr_src=1, result_src=00, mem_write=1. mem_write stays high while waiting. Goes to FETCH when mem_ready=1.
  - EXECR(6): alu_src_a=10, alu_src_b=00, ALUOp=10. Goes to ALUWB.
  - EXECI(7): alu_src_a=10, alu_src_b=01, ALUOp=10. Goes to ALUWB.
  - ALUWB(8): result_src=00, reg_write=1. Goes to FETCH.
  - BEQ(9): alu_src_a=10, alu_src_b=00, ALUOp=01, result_src=00, Branch=1. Goes to FETCH.
  - JAL(10): alu_src_a=01, alu_src_b=10, result_src=00, PCUpdate=1. Goes to ALUWB.
  - TRAP(11): illegal=1, all strobes 0. Held until reset.
  - Unused encodings (12-15) go to TRAP.
- instret increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It wraps from 2^CNT_W-1 to 0.
- Cycle counts with mem_ready held at 1: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly 1 cycle.

Test Plan:
- Apply reset for 2 cycles. Required: state_dbg=0, instret=0 and all strobes 0 during reset. ir_write=1 in the first post-reset cycle with mem_ready=1.
- add 0x002081B3 then sub 0x402081B3, mem_ready=1. Required: states 0,1,6,8, with alu_control 000 in EXECR for add and 001 for sub. reg_write=1 in the 4th cycle. instret goes 0->1->2.
- lw 0x00402103, with mem_ready=0 for 2 cycles in MEMREAD. Required: states 0,1,2,3,3,3,4 (7 cycles), reg_write only in MEMWB with result_src=01. sw 0x00202223: mem_write=1 in MEMWRITE only, 4 cycles.
- beq 0x00000463. With zero=1: pc_write=1 in the BEQ cycle and alu_control=001. With zero=0: pc_write=0. Each case lasts 3 cycles.
- jal 0x008000EF. Required: imm_src=11; pc_write=1 in both FETCH and JAL; reg_write=1 in ALUWB; 4 cycles.
- Opcode 0x00000000. Required: TRAP with illegal=1 for 10+ cycles and instret frozen. Reset then returns the FSM to FETCH with illegal=0.
